// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through data cache controller. It sequences CPU loads
// and stores against the tag/valid/data arrays and a single-request backing memory.
module dcache_ctrl #(
    parameter int LINES = 1024,
    parameter int IDX_W = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cpu_req,
    input  logic             cpu_we,
    input  logic [31:0]      cpu_addr,
    input  logic [31:0]      cpu_wdata,
    output logic [31:0]      cpu_rdata,
    output logic             cpu_ready,
    output logic             misalign,
    input  logic             inv_all,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int TAG_W = 32 - IDX_W - 2;

    // Handshake: cpu_req/cpu_we/cpu_addr/cpu_wdata are held by the requester until
    // cpu_ready pulses for one cycle; mem_req/mem_we/mem_addr/mem_wdata are held by
    // this block until mem_ack pulses for one cycle. mem_ack is ignored elsewhere.
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FILL,
        S_WRITE,
        S_RESP
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic               hit_q, hit_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [31:0]        cpu_rdata_q, cpu_rdata_d;
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]   miss_cnt_q, miss_cnt_d;

    logic [31:0]        data_mem [LINES];
    logic [TAG_W-1:0]   tag_mem  [LINES];

    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               lookup_hit;
    logic               arr_we;
    logic               arr_fill;
    logic [31:0]        arr_wdata;

    assign idx        = addr_q[IDX_W+1:2];
    assign tag        = addr_q[31:IDX_W+2];
    assign lookup_hit = valid_q[idx] && (tag_mem[idx] == tag);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        hit_d       = hit_q;
        valid_d     = valid_q;
        cpu_rdata_d = cpu_rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        arr_we      = 1'b0;
        arr_fill    = 1'b0;
        arr_wdata   = wdata_q;

        case (state_q)
            S_IDLE: begin
                // Invalidate wins; a coincident request is picked up next cycle.
                if (inv_all) begin
                    valid_d = '0;
                end else if (cpu_req) begin
                    addr_d  = cpu_addr;
                    we_d    = cpu_we;
                    wdata_d = cpu_wdata;
                    state_d = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                hit_d = lookup_hit;
                if (lookup_hit) begin
                    hit_cnt_d = sat_inc(hit_cnt_q);
                end else begin
                    miss_cnt_d = sat_inc(miss_cnt_q);
                end
                if (we_q) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {addr_q[31:2], 2'b00};
                    mem_wdata_d = wdata_q;
                    state_d     = S_WRITE;
                end else if (lookup_hit) begin
                    cpu_rdata_d = data_mem[idx];
                    state_d     = S_RESP;
                end else begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {addr_q[31:2], 2'b00};
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                if (mem_ack) begin
                    arr_we       = 1'b1;
                    arr_fill     = 1'b1;
                    arr_wdata    = mem_rdata;
                    valid_d[idx] = 1'b1;
                    cpu_rdata_d  = mem_rdata;
                    mem_req_d    = 1'b0;
                    state_d      = S_RESP;
                end
            end
            S_WRITE: begin
                // Write-through without allocate: only a resident line is updated.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    arr_we    = hit_q;
                    state_d   = S_RESP;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            hit_q       <= 1'b0;
            valid_q     <= '0;
            cpu_rdata_q <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            hit_q       <= hit_d;
            valid_q     <= valid_d;
            cpu_rdata_q <= cpu_rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag and data arrays carry no reset; the valid vector alone qualifies them.
    always_ff @(posedge clk) begin
        if (!reset && arr_we) begin
            data_mem[idx] <= arr_wdata;
            if (arr_fill) begin
                tag_mem[idx] <= tag;
            end
        end
    end

    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_ready  = (state_q == S_RESP);
    assign misalign   = (state_q == S_RESP) && (addr_q[1:0] != 2'b00);
    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

endmodule
